// File: rtl/clk_period_checker.sv
// Period checker for a divided clock generated in the clkin domain.
// Measures rise-to-rise spacing, acquires lock after LOCK_COUNT good periods, flags errors.
module clk_period_checker #(
  parameter int DIV_RATIO  = 8,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             sample,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic             err
);

  localparam int GW = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(DIV_RATIO - TOL);
  localparam logic [CNT_W-1:0] P_MAX   = CNT_W'(DIV_RATIO + TOL);
  localparam logic [GW-1:0]    LC_LAST = GW'(LOCK_COUNT - 1);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state;
  logic             s_q;
  logic [CNT_W-1:0] cnt;
  logic [GW-1:0]    good_cnt;

  logic             rise;
  logic [CNT_W-1:0] p_meas;
  logic             good;
  logic             timeout;

  always_comb begin
    rise    = sample & ~s_q;
    p_meas  = cnt + CNT_W'(1);
    good    = (p_meas >= P_MIN) && (p_meas <= P_MAX);
    // A rise on the threshold cycle wins and is measured instead.
    timeout = (state != IDLE) && !rise && (cnt == P_MAX);
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state        <= IDLE;
      s_q          <= 1'b0;
      cnt          <= '0;
      good_cnt     <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lock_lost    <= 1'b0;
      err          <= 1'b0;
    end else begin
      s_q          <= sample;
      period_valid <= 1'b0;
      lock_lost    <= 1'b0;
      if (rise)
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CNT_W'(1);

      // Error-setting assignments below are later in the block, so set beats clear.
      if (err_clr)
        err <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            state    <= ACQUIRE;
            good_cnt <= '0;
          end
        end
        ACQUIRE: begin
          if (rise) begin
            period       <= p_meas;
            period_valid <= 1'b1;
            if (good) begin
              good_cnt <= good_cnt + GW'(1);
              if (good_cnt == LC_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end else begin
              good_cnt <= '0;
              err      <= 1'b1;
            end
          end else if (timeout) begin
            state <= IDLE;
            err   <= 1'b1;
          end
        end
        LOCKED: begin
          if (rise) begin
            period       <= p_meas;
            period_valid <= 1'b1;
            if (!good) begin
              state     <= ACQUIRE;
              good_cnt  <= '0;
              err       <= 1'b1;
              locked    <= 1'b0;
              lock_lost <= 1'b1;
            end
          end else if (timeout) begin
            state     <= IDLE;
            err       <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_period_checker.sv
// Bench for clk_period_checker: cycle-accurate model based on elapsed time between rises,
// checked every cycle, plus literal checkpoints. dut0 uses defaults, dut1 uses TOL=1.
module tb_clk_period_checker;

  localparam int M_IDLE = 0;
  localparam int M_ACQ  = 1;
  localparam int M_LOCK = 2;

  typedef struct {
    int     mode;
    int     good;
    longint last;
    longint per;
    bit     pv;
    bit     lk;
    bit     ll;
    bit     er;
    bit     sq;
  } mdl_t;

  logic        clk;
  logic        reset;
  logic        sample0, sample1, errclr0, errclr1;
  logic [15:0] period0, period1;
  logic        pv0, pv1, locked0, locked1, ll0, ll1, err0, err1;

  int     tests = 0;
  int     fails = 0;
  int     pvc0  = 0;
  int     llc0  = 0;
  int     pv_snap;
  bit     armed = 0;
  longint t     = 0;
  mdl_t   m0, m1;

  clk_period_checker dut0 (
    .clkin(clk), .reset(reset), .sample(sample0), .err_clr(errclr0),
    .period(period0), .period_valid(pv0), .locked(locked0),
    .lock_lost(ll0), .err(err0)
  );

  clk_period_checker #(.DIV_RATIO(8), .TOL(1), .LOCK_COUNT(4), .CNT_W(16)) dut1 (
    .clkin(clk), .reset(reset), .sample(sample1), .err_clr(errclr1),
    .period(period1), .period_valid(pv1), .locked(locked1),
    .lock_lost(ll1), .err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: period is elapsed cycles since the previous rise; timeout when that
  // elapsed count reaches div+tol+1 without a rise.
  function automatic mdl_t step(mdl_t m, longint now, bit rst, bit smp, bit clr,
                                int div, int tol, int lc);
    mdl_t   n;
    bit     rise;
    longint p;
    n = m;
    if (rst) begin
      n.mode = M_IDLE; n.good = 0; n.last = now; n.per = 0;
      n.pv = 0; n.lk = 0; n.ll = 0; n.er = 0; n.sq = 0;
      return n;
    end
    rise = smp && !m.sq;
    n.sq = smp;
    n.pv = 0;
    n.ll = 0;
    if (clr) n.er = 0;
    p = now - m.last;
    if (rise) begin
      n.last = now;
      if (m.mode == M_IDLE) begin
        n.mode = M_ACQ;
        n.good = 0;
      end else begin
        n.per = p;
        n.pv  = 1;
        if (p >= div - tol && p <= div + tol) begin
          if (m.mode == M_ACQ) begin
            n.good = m.good + 1;
            if (n.good >= lc) n.mode = M_LOCK;
          end
        end else begin
          n.ll   = (m.mode == M_LOCK);
          n.mode = M_ACQ;
          n.good = 0;
          n.er   = 1;
        end
      end
    end else if (m.mode != M_IDLE && p == div + tol + 1) begin
      n.ll   = (m.mode == M_LOCK);
      n.mode = M_IDLE;
      n.er   = 1;
    end
    n.lk = (n.mode == M_LOCK);
    return n;
  endfunction

  always @(posedge clk) begin
    t++;
    m0 = step(m0, t, reset, sample0, errclr0, 8, 0, 4);
    m1 = step(m1, t, reset, sample1, errclr1, 8, 1, 4);
    if (reset) armed = 1;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("dut0.period",       period0, m0.per);
      chk("dut0.period_valid", pv0,     m0.pv);
      chk("dut0.locked",       locked0, m0.lk);
      chk("dut0.lock_lost",    ll0,     m0.ll);
      chk("dut0.err",          err0,    m0.er);
      chk("dut1.period",       period1, m1.per);
      chk("dut1.period_valid", pv1,     m1.pv);
      chk("dut1.locked",       locked1, m1.lk);
      chk("dut1.lock_lost",    ll1,     m1.ll);
      chk("dut1.err",          err1,    m1.er);
      if (pv0 === 1'b1) pvc0++;
      if (ll0 === 1'b1) llc0++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One sample period of p cycles starting with a rise; clr asserts err_clr on the rise cycle.
  task automatic per(input int sel, input int p, input bit clr);
    if (sel == 0) begin sample0 = 1'b1; errclr0 = clr; end
    else          begin sample1 = 1'b1; errclr1 = clr; end
    tick();
    errclr0 = 1'b0;
    errclr1 = 1'b0;
    ticks(p / 2 - 1);
    if (sel == 0) sample0 = 1'b0; else sample1 = 1'b0;
    ticks(p - p / 2);
  endtask

  initial begin
    reset = 1'b1; sample0 = 1'b0; sample1 = 1'b0; errclr0 = 1'b0; errclr1 = 1'b0;
    ticks(3);
    chk("rst.period", period0, 0);
    chk("rst.locked", locked0, 0);
    chk("rst.err",    err0,    0);
    chk("rst.pv",     pv0,     0);
    reset = 1'b0;

    // Clean lock
    for (int i = 0; i < 5; i++) per(0, 8, 0);
    chk("lock.locked", locked0, 1);
    chk("lock.period", period0, 8);
    chk("lock.err",    err0,    0);
    chk("lock.pv_count", pvc0, 4);
    chk("lock.model", m0.lk, 1);

    // Glitch of 9
    per(0, 9, 0);
    per(0, 8, 0);
    chk("glitch.period", period0, 9);
    chk("glitch.locked", locked0, 0);
    chk("glitch.err",    err0,    1);
    chk("glitch.ll_count", llc0, 1);
    for (int i = 0; i < 3; i++) per(0, 8, 0);
    chk("relock.early", locked0, 0);
    per(0, 8, 0);
    chk("relock.locked", locked0, 1);

    // err_clr alone, then with a bad period, then alone again
    per(0, 8, 1);
    chk("clr.err", err0, 0);
    per(0, 7, 0);
    per(0, 8, 1);
    chk("clrbad.err",    err0,    1);
    chk("clrbad.period", period0, 7);
    chk("clrbad.locked", locked0, 0);
    per(0, 8, 1);
    chk("clr2.err", err0, 0);
    for (int i = 0; i < 3; i++) per(0, 8, 0);
    chk("lock3.locked", locked0, 1);

    // Stall: last rise 7 cycles ago here
    tick();
    chk("stall.still_locked", locked0, 1);
    tick();
    chk("stall.locked",    locked0, 0);
    chk("stall.lock_lost", ll0,     1);
    chk("stall.err",       err0,    1);
    chk("stall.pv",        pv0,     0);
    chk("stall.model_ll",  m0.ll,   1);
    ticks(5);
    pv_snap = pvc0;
    per(0, 8, 0);
    chk("rearm.pv_count", pvc0, pv_snap);
    per(0, 8, 0);
    per(0, 8, 0);
    chk("acq2.locked", locked0, 0);

    // Reset mid-ACQUIRE
    reset = 1'b1;
    tick();
    chk("midrst.period", period0, 0);
    chk("midrst.err",    err0,    0);
    chk("midrst.locked", locked0, 0);
    chk("midrst.pv",     pv0,     0);
    chk("midrst.ll",     ll0,     0);
    reset = 1'b0;
    pv_snap = pvc0;
    for (int i = 0; i < 4; i++) per(0, 8, 0);
    chk("midrst.4rises", locked0, 0);
    per(0, 8, 0);
    chk("midrst.5rises", locked0, 1);
    chk("midrst.pv_count", pvc0 - pv_snap, 4);

    // Tolerance instance
    per(1, 8, 0);
    per(1, 7, 0);
    per(1, 9, 0);
    per(1, 7, 0);
    per(1, 9, 0);
    chk("tol.locked", locked1, 1);
    chk("tol.err",    err1,    0);
    chk("tol.period", period1, 7);
    per(1, 10, 0);
    chk("tol.p9.period", period1, 9);
    chk("tol.p9.locked", locked1, 1);
    per(1, 8, 0);
    chk("tol.p10.period", period1, 10);
    chk("tol.p10.err",    err1,    1);
    chk("tol.p10.locked", locked1, 0);
    ticks(15);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
